// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over one
// shared memory and ALU, flags illegal opcodes, counts retirements.
module multicycle_controller #(
  parameter int ICOUNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                iord,
  output logic                irwrite,
  output logic                pcen,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                memwrite,
  output logic [2:0]          alucontrol,
  output logic [3:0]          state,
  output logic                illegal,
  output logic [ICOUNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e                state_q, state_d;
  logic                  illegal_q, illegal_d;
  logic [ICOUNT_W-1:0]   retired_q, retired_d;
  logic                  retire;
  logic                  funct_ok;
  logic [2:0]            funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    unique case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    alucontrol = ALU_ADD;
    unique case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        unique case (1'b1)
          (op == OP_LW) || (op == OP_SW): state_d = MEMADR;
          (op == OP_R) && funct_ok:       state_d = EXEC;
          (op == OP_BEQ):                 state_d = BRANCH;
          (op == OP_ADDI):                state_d = ADDIEX;
          (op == OP_J):                   state_d = JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        state_d    = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // no architectural side effects may leak while reset is held
    if (!reset_n) begin
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
    retired_d = retired_q + ICOUNT_W'(retire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
